// File: rtl/fir_tap_engine.sv
// rtl/fir_tap_engine.sv - time-multiplexed FIR tap engine
//
// One sample in, TAPS serial multiply-accumulate cycles, one result out.
// Optional build macro: FIR_ROUND_SAT_EN (round half-up + saturate on output;
// default build truncates with an arithmetic shift and wraps).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   sample offered          in_ready   engine accepts a sample (IDLE)
//   in_data    signed sample, N bits
//   coef_we    coefficient write strobe (honoured in IDLE only)
//   coef_addr  coefficient index, 0 = tap applied to the newest sample
//   coef_data  signed coefficient, CW bits
//   coef_busy  high while not IDLE; coefficient writes are dropped
//   out_valid  result available       out_ready  consumer takes the result
//   out_data   signed filtered result, OW bits
module fir_tap_engine #(
  parameter int N     = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic                      coef_busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OW-1:0]             out_data
);

  localparam int PW  = $clog2(TAPS);
  localparam int PRW = N + CW;
  localparam int AW  = N + CW + $clog2(TAPS);
  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state_q;
  logic signed [N-1:0]   hist_q [TAPS];
  logic signed [CW-1:0]  coef_q [TAPS];
  logic signed [AW-1:0]  acc_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         newest_q;
  logic [PW-1:0]         k_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [OW-1:0]         out_data_q;

  logic [PW-1:0]         rd_idx;
  logic signed [PRW-1:0] prod;
  logic signed [AW-1:0]  acc_d;
  logic [OW-1:0]         scaled;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_busy = (state_q != IDLE);

  // Tap k reads the sample k steps older than the newest one; explicit wrap
  // keeps this correct when TAPS is not a power of two.
  always_comb begin
    rd_idx = '0;
    if (newest_q >= k_q) begin
      rd_idx = newest_q - k_q;
    end else begin
      rd_idx = PW'(int'(newest_q) + TAPS - int'(k_q));
    end
  end

  assign prod  = hist_q[rd_idx] * coef_q[k_q];
  assign acc_d = acc_q + {{(AW-PRW){prod[PRW-1]}}, prod};

`ifdef FIR_ROUND_SAT_EN
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [AW:0] ONE     = 1;
  localparam logic signed [AW:0] RND_ADD = (SHIFT > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [AW:0] SMAX    = (ONE <<< (OW - 1)) - ONE;
  localparam logic signed [AW:0] SMIN    = -(ONE <<< (OW - 1));

  logic signed [AW:0] rnd;
  logic signed [AW:0] shf;

  // One extra bit so the rounding add cannot overflow before saturation.
  always_comb begin
    rnd    = {acc_q[AW-1], acc_q} + RND_ADD;
    shf    = rnd >>> SHIFT;
    scaled = shf[OW-1:0];
    if (shf > SMAX) begin
      scaled = SMAX[OW-1:0];
    end else if (shf < SMIN) begin
      scaled = SMIN[OW-1:0];
    end
  end
`else
  always_comb begin
    scaled = OW'(acc_q >>> SHIFT);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      acc_q       <= '0;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (coef_we && (state_q == IDLE) && (coef_addr <= LAST)) begin
        coef_q[coef_addr] <= coef_data;
      end

      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            hist_q[wr_ptr_q] <= in_data;
            newest_q         <= wr_ptr_q;
            wr_ptr_q         <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            acc_q            <= '0;
            k_q              <= '0;
            in_ready_q       <= 1'b0;
            state_q          <= MAC;
          end
        end

        MAC: begin
          acc_q <= acc_d;
          if (k_q == LAST) begin
            state_q <= OUT;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end

        // First OUT cycle registers the scaled result from the finished
        // accumulator; out_data then holds until the consumer takes it.
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= scaled;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
